// File: rtl/simple_datapath.sv
// Execution datapath: register file, immediate/operand registers, B-operand mux,
// ALU with registered result and zero/carry flags, driven by the controller's enables.
module simple_datapath #(
   parameter int DW   = 8,
   parameter int NREG = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_rf,
   input  logic          r_wf,
   input  logic [3:0]    sel_rf,
   input  logic          en_imm,
   input  logic [DW-1:0] imm,
   input  logic          sel_mux,
   input  logic          en_reg,
   input  logic          en_alu,
   input  logic [2:0]    sel_alu,
   output logic          alu_zero,
   output logic          alu_carry,
   output logic [DW-1:0] ram_wdata,
   input  logic [3:0]    dbg_sel,
   output logic [DW-1:0] dbg_data
);

   typedef enum logic [2:0] {
      OP_PASS = 3'b000,
      OP_TEST = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_SHL  = 3'b100
   } alu_op_e;

   logic [DW-1:0] r_rf [NREG];
   logic [DW-1:0] r_imm_q;
   logic [DW-1:0] r_rf_q;
   logic [DW-1:0] r_reg_a;
   logic [DW-1:0] r_alu_q;
   logic          r_zero;
   logic          r_carry;

   logic [DW-1:0] w_mux_b;
   logic [DW-1:0] w_rf_rd;
   logic [DW-1:0] w_dbg;
   logic [DW:0]   w_sum;
   logic [DW:0]   w_diff;
   logic [DW:0]   w_shl_ext;
   logic [DW-1:0] w_alu_r;
   logic          w_alu_c;
   logic          w_alu_upd;

   assign w_mux_b = sel_mux ? r_rf_q : r_imm_q;

   // Out-of-range indices never match a loop index, so they read as 0.
   always_comb begin
      w_rf_rd = '0;
      w_dbg   = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (sel_rf == 4'(i))  w_rf_rd = r_rf[i];
         if (dbg_sel == 4'(i)) w_dbg   = r_rf[i];
      end
   end

   assign w_sum  = {1'b0, r_reg_a} + {1'b0, w_mux_b};
   assign w_diff = {1'b0, r_reg_a} - {1'b0, w_mux_b};
   // One extra MSB catches the last bit shifted out; shifts beyond DW clear everything.
   assign w_shl_ext = {1'b0, w_mux_b} << r_reg_a;

   always_comb begin
      w_alu_r   = '0;
      w_alu_c   = 1'b0;
      w_alu_upd = 1'b1;
      case (sel_alu)
         OP_PASS, OP_TEST: w_alu_r = w_mux_b;
         OP_ADD: begin
            w_alu_r = w_sum[DW-1:0];
            w_alu_c = w_sum[DW];
         end
         OP_SUB: begin
            w_alu_r = w_diff[DW-1:0];
            w_alu_c = w_diff[DW];
         end
         OP_SHL: begin
            w_alu_r = w_shl_ext[DW-1:0];
            w_alu_c = w_shl_ext[DW];
         end
         default: w_alu_upd = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
         r_imm_q <= '0;
         r_rf_q  <= '0;
         r_reg_a <= '0;
         r_alu_q <= '0;
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
      end else begin
         if (en_imm) r_imm_q <= imm;
         if (en_reg) r_reg_a <= w_mux_b;
         if (en_rf && r_wf) r_rf_q <= w_rf_rd;
         if (en_rf && !r_wf) begin
            for (int unsigned i = 0; i < NREG; i++) begin
               if (sel_rf == 4'(i)) r_rf[i] <= r_alu_q;
            end
         end
         if (en_alu && w_alu_upd) begin
            r_alu_q <= w_alu_r;
            r_zero  <= (w_alu_r == '0);
            r_carry <= w_alu_c;
         end
      end
   end

   assign alu_zero  = r_zero;
   assign alu_carry = r_carry;
   assign ram_wdata = r_alu_q;
   assign dbg_data  = w_dbg;

endmodule

// File: tb/tb_simple_datapath.sv
// Directed self-checking bench for simple_datapath (NREG reduced to 12 to reach the out-of-range index cases).
`timescale 1ns/100ps
module tb_simple_datapath;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en_rf = 1'b0, r_wf = 1'b0, en_imm = 1'b0, sel_mux = 1'b0;
   logic          en_reg = 1'b0, en_alu = 1'b0;
   logic [3:0]    sel_rf = '0, dbg_sel = '0;
   logic [2:0]    sel_alu = '0;
   logic [DW-1:0] imm = '0;
   logic          alu_zero, alu_carry;
   logic [DW-1:0] ram_wdata, dbg_data;

   int errors = 0;
   int checks = 0;

   simple_datapath #(.DW(DW), .NREG(12)) dut (
      .clk(clk), .rst_n(rst_n), .en_rf(en_rf), .r_wf(r_wf), .sel_rf(sel_rf),
      .en_imm(en_imm), .imm(imm), .sel_mux(sel_mux), .en_reg(en_reg),
      .en_alu(en_alu), .sel_alu(sel_alu), .alu_zero(alu_zero),
      .alu_carry(alu_carry), .ram_wdata(ram_wdata), .dbg_sel(dbg_sel),
      .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en_rf = 0; r_wf = 0; en_imm = 0; en_reg = 0; en_alu = 0;
   endtask

   task automatic chk_alu(input string tag, input logic [7:0] q, input logic z, input logic c);
      chk({tag, ".q"}, ram_wdata, q);
      chk({tag, ".z"}, alu_zero, z);
      chk({tag, ".c"}, alu_carry, c);
   endtask

   task automatic chk_rf(input string tag, input logic [3:0] idx, input logic [7:0] v);
      dbg_sel = idx;
      #0.1;
      chk(tag, dbg_data, v);
   endtask

   task automatic load_rf(input logic [3:0] idx, input logic [7:0] v);
      idle(); imm = v; en_imm = 1; cyc();
      idle(); sel_mux = 0; sel_alu = 3'b000; en_alu = 1; cyc();
      idle(); en_rf = 1; r_wf = 0; sel_rf = idx; cyc();
      idle();
   endtask

   // reg_a <- rf[ia], rf_q <- rf[ib], then one ALU op with B = rf_q
   task automatic binop(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] op);
      idle(); en_rf = 1; r_wf = 1; sel_rf = ia; cyc();
      idle(); sel_mux = 1; en_reg = 1; en_rf = 1; r_wf = 1; sel_rf = ib; cyc();
      idle(); sel_mux = 1; sel_alu = op; en_alu = 1; cyc();
      idle();
   endtask

   task automatic set_reg_a_imm(input logic [7:0] v);
      idle(); imm = v; en_imm = 1; cyc();
      idle(); sel_mux = 0; en_reg = 1; cyc();
      idle();
   endtask

   initial begin
      repeat (2) cyc();
      chk_alu("por", 8'h00, 1'b0, 1'b0);
      rst_n = 1; cyc();

      // Mid-cycle asynchronous reset with a preloaded file
      load_rf(4'd3, 8'hA5);
      load_rf(4'd7, 8'h3C);
      chk_rf("preload.rf3", 4'd3, 8'hA5);
      chk("preload.q", ram_wdata, 8'h3C);
      #1 rst_n = 0;
      #1;
      chk_alu("arst", 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) chk_rf($sformatf("arst.rf%0d", i), 4'(i), 8'h00);
      cyc(); rst_n = 1; cyc();

      // LOADI
      idle(); imm = 8'h5A; en_imm = 1; cyc();
      idle(); sel_mux = 0; sel_alu = 3'b000; en_alu = 1; cyc();
      chk_alu("loadi", 8'h5A, 1'b0, 1'b0);
      idle(); en_rf = 1; r_wf = 0; sel_rf = 4'd3; cyc(); idle();
      chk_rf("loadi.rf3", 4'd3, 8'h5A);

      // ADD with carry, write back
      load_rf(4'd1, 8'hF0);
      load_rf(4'd2, 8'h20);
      binop(4'd1, 4'd2, 3'b010);
      chk_alu("add", 8'h10, 1'b0, 1'b1);
      en_rf = 1; r_wf = 0; sel_rf = 4'd2; cyc(); idle();
      chk_rf("add.wb", 4'd2, 8'h10);
      chk_rf("add.rf1", 4'd1, 8'hF0);

      // SUB zero and borrow
      load_rf(4'd4, 8'h33);
      load_rf(4'd5, 8'h33);
      binop(4'd4, 4'd5, 3'b011);
      chk_alu("sub.eq", 8'h00, 1'b1, 1'b0);
      load_rf(4'd5, 8'h34);
      binop(4'd4, 4'd5, 3'b011);
      chk_alu("sub.brw", 8'hFF, 1'b0, 1'b1);

      // SHL
      load_rf(4'd6, 8'h81);
      set_reg_a_imm(8'd3);
      en_rf = 1; r_wf = 1; sel_rf = 4'd6; cyc(); idle();
      sel_mux = 1; sel_alu = 3'b100; en_alu = 1; cyc(); idle();
      chk_alu("shl3", 8'h08, 1'b0, 1'b0);
      set_reg_a_imm(8'd1);
      sel_mux = 1; sel_alu = 3'b100; en_alu = 1; cyc(); idle();
      chk_alu("shl1", 8'h02, 1'b0, 1'b1);
      set_reg_a_imm(8'd8);
      sel_mux = 1; sel_alu = 3'b100; en_alu = 1; cyc(); idle();
      chk_alu("shl8", 8'h00, 1'b1, 1'b1);
      set_reg_a_imm(8'd1);
      sel_mux = 1; sel_alu = 3'b100; en_alu = 1; cyc(); idle();

      // Reserved opcodes hold result and flags
      for (int op = 5; op < 8; op++) begin
         sel_mux = 1; sel_alu = 3'(op); en_alu = 1; cyc(); idle();
         chk_alu($sformatf("rsv%0d", op), 8'h02, 1'b0, 1'b1);
      end

      set_reg_a_imm(8'd9);
      sel_mux = 1; sel_alu = 3'b100; en_alu = 1; cyc(); idle();
      chk_alu("shl9", 8'h00, 1'b1, 1'b0);

      // Hold with all enables low while other inputs wiggle
      for (int k = 0; k < 5; k++) begin
         imm = 8'(8'hC3 + k); sel_rf = 4'(k); sel_alu = 3'(k); sel_mux = k[0];
         cyc();
      end
      idle();
      chk_alu("hold", 8'h00, 1'b1, 1'b0);
      chk_rf("hold.rf6", 4'd6, 8'h81);
      chk_rf("hold.rf3", 4'd3, 8'h5A);
      sel_mux = 1; sel_alu = 3'b001; en_alu = 1; cyc(); idle();
      chk_alu("hold.rfq", 8'h81, 1'b0, 1'b0);
      sel_mux = 0; sel_alu = 3'b000; en_alu = 1; cyc(); idle();
      chk_alu("hold.imm", 8'h09, 1'b0, 1'b0);

      // Collisions: en_reg+en_alu (reg_a=9 old, imm_q=4)
      imm = 8'd4; en_imm = 1; cyc(); idle();
      sel_mux = 0; sel_alu = 3'b010; en_reg = 1; en_alu = 1; cyc(); idle();
      chk_alu("col.reg", 8'h0D, 1'b0, 1'b0);
      sel_mux = 0; sel_alu = 3'b010; en_alu = 1; cyc(); idle();
      chk_alu("col.reg2", 8'h08, 1'b0, 1'b0);
      imm = 8'd7; en_imm = 1; sel_mux = 0; sel_alu = 3'b000; en_alu = 1; cyc(); idle();
      chk_alu("col.imm", 8'h04, 1'b0, 1'b0);
      en_rf = 1; r_wf = 0; sel_rf = 4'd7; sel_mux = 0; sel_alu = 3'b000; en_alu = 1; cyc(); idle();
      chk_alu("col.wr", 8'h07, 1'b0, 1'b0);
      chk_rf("col.wr.rf7", 4'd7, 8'h04);
      en_rf = 1; r_wf = 1; sel_rf = 4'd1; sel_mux = 1; sel_alu = 3'b000; en_alu = 1; cyc(); idle();
      chk_alu("col.rd", 8'h81, 1'b0, 1'b0);

      // Indices beyond NREG: write ignored, read and debug return 0
      en_rf = 1; r_wf = 0; sel_rf = 4'd13; cyc(); idle();
      chk_rf("oor.dbg13", 4'd13, 8'h00);
      chk_rf("oor.rf1", 4'd1, 8'hF0);
      en_rf = 1; r_wf = 1; sel_rf = 4'd14; cyc(); idle();
      sel_mux = 1; sel_alu = 3'b001; en_alu = 1; cyc(); idle();
      chk_alu("oor.rd", 8'h00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/simple_datapath.md
Name: simple_datapath

Overview:
- Execution datapath for the simple processor. It is the slave side of the controller's control bus.
- Contains the register file, the immediate register, operand register A, the B-operand mux, the ALU with its result register, and the zero/carry flags.
- Consumes the controller's enables and selects, returns alu_zero, and supplies store data to the data RAM.

Parameters:
- DW, 8, data width of registers, immediate and ALU.
- NREG, 16, number of register-file entries; sel_rf width fixed at 4, so NREG must not exceed 16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_rf  input  1  register-file access enable, level-sensitive.
- r_wf  input  1  register-file direction: 1 = read into rf_q, 0 = write alu_q into the file.
- sel_rf  input  4  register-file index.
- en_imm  input  1  load imm into imm_q.
- imm  input  DW  immediate value from the controller.
- sel_mux  input  1  B-operand select: 1 = rf_q, 0 = imm_q.
- en_reg  input  1  load the B-mux output into reg_a.
- en_alu  input  1  update alu_q and the flags.
- sel_alu  input  3  ALU operation.
- alu_zero  output  1  registered zero flag of the last ALU update.
- alu_carry  output  1  registered carry/borrow flag.
- ram_wdata  output  DW  store data to the RAM; equals alu_q.
- dbg_sel  input  4  debug read index.
- dbg_data  output  DW  combinational rf[dbg_sel], for the testbench.

Behaviour:
- Reset (async, rst_n=0): all RF entries, imm_q, rf_q, reg_a and alu_q clear to 0; alu_zero=0; alu_carry=0; ram_wdata=0. Reset mid-operation discards everything. The first rising edge after release behaves normally.
- All enables are level-sensitive. Each enabled register updates on every rising edge while its enable is high, and holds when it is low.
- B-mux (combinational): mux_b = sel_mux ? rf_q : imm_q.
- imm_q <= imm when en_imm.
- reg_a <= mux_b when en_reg.
- RF read (en_rf=1, r_wf=1): rf_q <= rf[sel_rf]. Latency is one cycle; the RF contents are unchanged.
- RF write (en_rf=1, r_wf=0): rf[sel_rf] <= alu_q, using the value of alu_q before the same edge. rf_q holds.
- en_rf=0: rf_q holds and the RF is unchanged.
- sel_rf >= NREG: the read returns 0 and the write is ignored.
- ALU update, when en_alu=1, with result r and the flags registered on the same edge:
  - 000 PASS: r = mux_b; carry=0.
  - 001 TEST: r = mux_b; carry=0. Used by jz.
  - 010 ADD: r = reg_a + mux_b, truncated to DW; carry = bit DW of the full sum.
  - 011 SUB: r = reg_a - mux_b, modulo 2^DW; carry=1 when reg_a < mux_b (borrow).
  - 100 SHL: r = mux_b << reg_a. r = 0 when reg_a >= DW. carry = the last bit shifted out; carry=0 when reg_a is 0 or reg_a > DW.
  - 101-111: reserved. alu_q, alu_zero and alu_carry all hold.
- alu_zero <= (r == 0) on every non-reserved ALU update.
- Simultaneous events:
  - en_reg and en_alu on the same edge: the ALU uses the old reg_a.
  - en_imm and en_alu: the ALU uses the old imm_q.
  - RF read and en_alu: the ALU uses the old rf_q.
  - RF write and en_alu: the old alu_q is written.
- dbg_data: combinational rf[dbg_sel]; returns 0 for indices >= NREG.

Test Plan:
- Reset: rst_n=0 mid-cycle with the RF preloaded -> dbg_data=0 for every index; alu_zero=0; alu_carry=0; ram_wdata=0. The clear is asynchronous, with no clock edge needed.
- LOADI: imm=8'h5A, en_imm; then sel_mux=0, en_alu with op 000; then en_rf=1, r_wf=0, sel_rf=3 -> rf[3]=5A, alu_zero=0, ram_wdata=5A.
- ADD carry: rf[1]=F0, rf[2]=20; read rf[1], sel_mux=1, en_reg; read rf[2], op 010 -> alu_q=10, carry=1, zero=0. Write back to r2 -> dbg rf[2]=10.
- SUB zero: rf[4]=rf[5]=33; sequence as ADD with op 011 -> alu_q=00, zero=1, carry=0. With rf[5]=34 -> alu_q=FF, carry=1.
- SHL: imm=3 into reg_a via sel_mux=0 and en_reg; rf[6]=81 read with sel_mux=1, op 100 -> alu_q=08, carry=0. With imm=1 -> alu_q=02, carry=1. With imm=9 -> alu_q=00, zero=1.
- Reserved and hold: op 110 with en_alu -> alu_q and flags unchanged. Deassert all enables for 5 cycles -> every register holds.
- Collision: en_reg and en_alu on the same edge -> the ALU result reflects the old reg_a.
